// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// imem_pkg: shared constants, loader state encoding and length check.
// Revision: 1.0
// ============================================================================
package imem_pkg;

  localparam int unsigned IMEM_BYTES = 2048;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_e;

  // Image length must be nonzero, whole words, and fit above the base address.
  function automatic logic length_ok(input logic [31:0] len,
                                     input logic [31:0] mem_bytes,
                                     input logic [31:0] base_addr);
    return (len != 32'd0) && (len[1:0] == 2'b00) && (len <= (mem_bytes - base_addr));
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
// word_assembler: 8-to-32 big-endian shift register with lane counter.
// Revision: 1.0
// ============================================================================
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  // Only the three older bytes need storage; the fourth arrives with the pulse.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  lane_q, lane_d;

  always_comb begin
    shift_d         = shift_q;
    lane_d          = lane_q;
    word_o          = {shift_q, byte_i};
    word_complete_o = shift_i && (lane_q == 2'd3);
    if (clear_i) begin
      shift_d = 24'd0;
      lane_d  = 2'd0;
    end else if (shift_i) begin
      shift_d = {shift_q[15:0], byte_i};
      lane_d  = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= 24'd0;
      lane_q  <= 2'd0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader: byte stream to big-endian word writer for instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to add the checksum_o XOR-of-words output.
// Revision: 1.0
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = IMEM_BYTES,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] length_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        busy_o,
  output logic        done_o,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0] checksum_o,
`endif
  output logic        error_o
);

  loader_state_e state_q, state_d;
  logic [31:0]   len_q, len_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          error_q, error_d;
  logic          handshake;
  logic          asm_clear;
  logic [31:0]   asm_word;
  logic          asm_complete;

  word_assembler u_word_assembler (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (asm_clear),
    .shift_i         (handshake),
    .byte_i          (byte_data_i),
    .word_o          (asm_word),
    .word_complete_o (asm_complete)
  );

  assign byte_ready_o = (state_q == ST_LOAD);
  assign handshake    = byte_valid_i && byte_ready_o;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    error_d   = error_q;
    asm_clear = 1'b0;

    // The write strobe is registered, giving the one-cycle write latency.
    if (asm_complete) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = asm_word;
      addr_d    = addr_q + 32'(WORD_BYTES);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (length_ok(length_i, 32'(MEM_BYTES), 32'(BASE_ADDR))) begin
            len_d     = length_i;
            addr_d    = 32'(BASE_ADDR);
            count_d   = 32'd0;
            error_d   = 1'b0;
            asm_clear = 1'b1;
            state_d   = ST_LOAD;
          end else begin
            error_d = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          count_d = count_q + 32'd1;
          if ((count_q + 32'd1) == len_q) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      len_q     <= 32'd0;
      count_q   <= 32'd0;
      addr_q    <= 32'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 32'd0;
      wr_data_q <= 32'd0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      error_q   <= error_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == ST_IDLE && start_i &&
        length_ok(length_i, 32'(MEM_BYTES), 32'(BASE_ADDR)))
      checksum_d = 32'd0;
    else if (asm_complete)
      checksum_d = checksum_q ^ asm_word;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) checksum_q <= 32'd0;
    else       checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`endif

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign done_o    = (state_q == ST_DONE);
  assign error_o   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader: randomized self-checking bench for imem_loader.
// Revision: 1.0
// ============================================================================
module tb_imem_loader;

  localparam int unsigned MEM  = 2048;
  localparam int unsigned BASE = 0;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] length_i = 32'd0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'd0;
  wire         byte_ready_o;
  wire         wr_en_o;
  wire  [31:0] wr_addr_o;
  wire  [31:0] wr_data_o;
  wire         busy_o;
  wire         done_o;
  wire         error_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
  wire  [31:0] checksum_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] img[$];

  imem_loader #(.MEM_BYTES(MEM), .BASE_ADDR(BASE)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .length_i     (length_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum_o   (checksum_o),
`endif
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Loads img[0..len-1]. mode 0: valid every cycle, 1: every other cycle,
  // 2: random. A second start_i with length 4 is pulsed at cycle glitch_at.
  task automatic do_load(input int len, input int mode, input int glitch_at);
    int          n = 0;
    int          cyc = 0;
    int          budget = 4 * len + 50;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] pend_data = 32'd0;
    logic [31:0] xsum = 32'd0;
    logic        hs;

    start_i = 1'b1; length_i = 32'(len); byte_valid_i = 1'b0;
    cycle();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL start_accept: busy=%b error=%b expected busy=1 error=0", busy_o, error_o);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (checksum_o !== 32'd0) begin
      errors++;
      $display("FAIL checksum_clear: got %h expected 00000000", checksum_o);
    end
`endif

    while (n < len && cyc < budget) begin
      checks++;
      if (wr_en_o !== pend) begin
        errors++;
        $display("FAIL wr_en_timing: got %b expected %b at byte %0d", wr_en_o, pend, n);
      end else if (pend && (wr_addr_o !== pend_addr || wr_data_o !== pend_data)) begin
        errors++;
        $display("FAIL write_word: got %h@%h expected %h@%h", wr_data_o, wr_addr_o, pend_data, pend_addr);
      end
      checks++;
      if (byte_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL ready_in_load: got %b expected 1", byte_ready_o);
      end
      pend = 1'b0;
      case (mode)
        0:       byte_valid_i = 1'b1;
        1:       byte_valid_i = (cyc % 2 == 1);
        default: byte_valid_i = 1'($urandom_range(0, 1));
      endcase
      byte_data_i = img[n];
      if (cyc == glitch_at) begin
        start_i = 1'b1; length_i = 32'd4;
      end else begin
        start_i = 1'b0;
      end
      hs = byte_valid_i && byte_ready_o;
      cycle();
      cyc++;
      if (hs) begin
        n++;
        if (n % 4 == 0) begin
          pend      = 1'b1;
          pend_addr = 32'(BASE) + 32'(n - 4);
          pend_data = {img[n-4], img[n-3], img[n-2], img[n-1]};
          xsum      = xsum ^ pend_data;
        end
      end
    end
    start_i = 1'b0;
    checks++;
    if (n < len) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d expected %0d", n, len);
    end

    // Final-word flush cycle; keep offering junk to prove nothing more is taken.
    byte_valid_i = 1'b1; byte_data_i = 8'hEE;
    checks++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== pend_addr || wr_data_o !== pend_data) begin
      errors++;
      $display("FAIL flush_write: got en=%b %h@%h expected en=1 %h@%h", wr_en_o, wr_data_o, wr_addr_o, pend_data, pend_addr);
    end
    checks++;
    if (byte_ready_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: ready=%b busy=%b done=%b expected 0 1 0", byte_ready_o, busy_o, done_o);
    end
    cycle();
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || wr_en_o !== 1'b0 || byte_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b wr_en=%b ready=%b expected 1 0 0 0", done_o, busy_o, wr_en_o, byte_ready_o);
    end
    checks++;
    if (wr_addr_o !== pend_addr || wr_data_o !== pend_data) begin
      errors++;
      $display("FAIL write_hold: got %h@%h expected %h@%h", wr_data_o, wr_addr_o, pend_data, pend_addr);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (checksum_o !== xsum) begin
      errors++;
      $display("FAIL checksum_done: got %h expected %h", checksum_o, xsum);
    end
`endif
    cycle();
    checks++;
    if (done_o !== 1'b0 || byte_ready_o !== 1'b0 || wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%b ready=%b wr_en=%b expected 0 0 0", done_o, byte_ready_o, wr_en_o);
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({byte_ready_o, wr_en_o, busy_o, done_o, error_o} !== 5'b0 ||
        wr_addr_o !== 32'd0 || wr_data_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b addr=%h data=%h expected all zero",
               {byte_ready_o, wr_en_o, busy_o, done_o, error_o}, wr_addr_o, wr_data_o);
    end
    rst_i = 1'b0;
    byte_valid_i = 1'b1;
    cycle();
    checks++;
    if (byte_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: ready=%b busy=%b expected 0 0", byte_ready_o, busy_o);
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_load(8, 0, -1);
  endtask

  task automatic test_throttled();
    img = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(4, 1, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int len = 4 * int'($urandom_range(1, 16));
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      do_load(len, 2, -1);
    end
  endtask

  task automatic test_bad_length();
    logic [31:0] bad[4];
    bad[0] = 32'd6; bad[1] = 32'd0; bad[2] = 32'd2052;
    bad[3] = 32'($urandom_range(1, 500)) * 32'd4 + 32'd1;
    for (int i = 0; i < 4; i++) begin
      start_i = 1'b1; length_i = bad[i]; byte_valid_i = 1'b1;
      cycle();
      start_i = 1'b0;
      checks++;
      if (error_o !== 1'b1 || wr_en_o !== 1'b0 || byte_ready_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL bad_len_%0d: error=%b wr_en=%b ready=%b busy=%b expected 1 0 0 0",
                 bad[i], error_o, wr_en_o, byte_ready_o, busy_o);
      end
      cycle();
      checks++;
      if (error_o !== 1'b1 || byte_ready_o !== 1'b0 || wr_en_o !== 1'b0) begin
        errors++;
        $display("FAIL error_sticky: error=%b ready=%b wr_en=%b expected 1 0 0", error_o, byte_ready_o, wr_en_o);
      end
    end
    byte_valid_i = 1'b0;
    img = {8'h12, 8'h34, 8'h56, 8'h78};
    do_load(4, 0, -1);
  endtask

  task automatic test_reset_midload();
    start_i = 1'b1; length_i = 32'd4;
    cycle();
    start_i = 1'b0;
    byte_valid_i = 1'b1; byte_data_i = 8'h9A;
    cycle();
    byte_data_i = 8'hBC;
    cycle();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({byte_ready_o, wr_en_o, busy_o, done_o, error_o} !== 5'b0 ||
        wr_addr_o !== 32'd0 || wr_data_o !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: ctl=%b addr=%h data=%h expected all zero",
               {byte_ready_o, wr_en_o, busy_o, done_o, error_o}, wr_addr_o, wr_data_o);
    end
    cycle();
    cycle();
    checks++;
    if (wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_write: wr_en=%b expected 0", wr_en_o);
    end
    rst_i = 1'b0;
    byte_valid_i = 1'b0;
    cycle();
    img = {8'hC0, 8'hDE, 8'hF0, 8'h0D};
    do_load(4, 0, -1);
  endtask

  task automatic test_start_ignored();
    img.delete();
    for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
    do_load(12, 0, 5);
  endtask

  task automatic test_full_memory();
    img.delete();
    for (int i = 0; i < int'(MEM - BASE); i++) img.push_back(8'($urandom));
    do_load(int'(MEM - BASE), 0, -1);
  endtask

  task automatic test_checksum();
    img = {8'h11, 8'h22, 8'h33, 8'h44, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
    do_load(8, 0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (checksum_o !== 32'h1E2D3C4B) begin
      errors++;
      $display("FAIL checksum_value: got %h expected 1e2d3c4b", checksum_o);
    end
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_throttled();
    test_random();
    test_bad_length();
    test_reset_midload();
    test_start_ignored();
    test_full_memory();
    test_checksum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
